// File: rtl/cobra_boot_loader_if.sv
// rtl/cobra_boot_loader_if.sv - byte-stream, instruction-RAM write and core-control signals of the boot loader
// slave is the loader; master is whatever feeds bytes and watches the result.
interface cobra_boot_loader_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        reload_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    modport slave (
        input  rx_data_i, rx_valid_i, reload_i,
        output rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output core_rst_o, busy_o, done_o, err_o
    );

    modport master (
        output rx_data_i, rx_valid_i, reload_i,
        input  rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  core_rst_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/cobra_boot_loader.sv
// rtl/cobra_boot_loader.sv - loads a length-prefixed, XOR-checked program into instruction RAM
// The core is held in reset until the whole program has been written and the checksum matches.
module cobra_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cobra_boot_loader_if.slave   if_bus
);
    localparam int             IW    = ADDR_W + 1;
    localparam logic [16:0]    MAX_N = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    logic [15:0]     r_len;
    logic [7:0]      r_xor;
    logic [1:0]      r_bcnt;
    logic [23:0]     r_asm;
    logic [IW-1:0]   r_widx;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;

    logic            w_ready;
    logic            w_accept;
    logic [7:0]      w_byte;
    logic [15:0]     w_len_full;
    logic [IW-1:0]   w_next_idx;

    assign w_ready    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CHK);
    assign w_accept   = if_bus.rx_valid_i & w_ready;
    assign w_byte     = if_bus.rx_data_i;
    assign w_len_full = {w_byte, r_len[7:0]};
    assign w_next_idx = r_widx + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_LEN_LO;
            r_len   <= '0;
            r_xor   <= '0;
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_widx  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (if_bus.reload_i) begin
                r_state <= S_LEN_LO;
                r_xor   <= '0;
                r_bcnt  <= '0;
                r_asm   <= '0;
                r_widx  <= '0;
            end else if (w_accept) begin
                case (r_state)
                    S_LEN_LO: begin
                        r_len[7:0] <= w_byte;
                        r_xor      <= w_byte;
                        r_state    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        r_len[15:8] <= w_byte;
                        r_xor       <= r_xor ^ w_byte;
                        if ({1'b0, w_len_full} > MAX_N)
                            r_state <= S_ERR;
                        else if (w_len_full == 16'd0)
                            r_state <= S_CHK;
                        else
                            r_state <= S_DATA;
                    end
                    S_DATA: begin
                        r_xor <= r_xor ^ w_byte;
                        if (r_bcnt == 2'd3) begin
                            // Fourth byte completes the word; first byte received lands in bits 7:0.
                            r_we    <= 1'b1;
                            r_addr  <= 32'({r_widx, 2'b00});
                            r_wdata <= {w_byte, r_asm};
                            r_widx  <= w_next_idx;
                            r_bcnt  <= 2'd0;
                            if (17'(w_next_idx) == {1'b0, r_len})
                                r_state <= S_CHK;
                        end else begin
                            r_asm  <= {w_byte, r_asm[23:8]};
                            r_bcnt <= r_bcnt + 2'd1;
                        end
                    end
                    S_CHK: begin
                        r_state <= (w_byte == r_xor) ? S_DONE : S_ERR;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign if_bus.rx_ready_o  = w_ready;
    assign if_bus.busy_o      = w_ready;
    assign if_bus.done_o      = (r_state == S_DONE);
    assign if_bus.err_o       = (r_state == S_ERR);
    assign if_bus.core_rst_o  = (r_state != S_DONE);
    assign if_bus.mem_we_o    = r_we;
    assign if_bus.mem_addr_o  = r_addr;
    assign if_bus.mem_wdata_o = r_wdata;
endmodule

// File: tb/tb_cobra_boot_loader.sv
// tb/tb_cobra_boot_loader.sv - directed and randomized load streams checked against a stream-level model
// The model parses whole byte streams; a monitor collects the writes the loader actually issues.
module tb_cobra_boot_loader;
    localparam int ADDR_W = 10;
    localparam int MAX_N  = 2 ** ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    cobra_boot_loader_if bus ();

    cobra_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .if_bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int base = 0;
    int done_cyc = -1;
    int err_cyc  = -1;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) edge_cnt++;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.mem_we_o) begin
                obs_addr.push_back(bus.mem_addr_o);
                obs_data.push_back(bus.mem_wdata_o);
                obs_cyc.push_back(edge_cnt - base + 1);
            end
            if (bus.done_o && done_cyc < 0) done_cyc = edge_cnt - base + 1;
            if (bus.err_o && err_cyc < 0)   err_cyc  = edge_cnt - base + 1;
        end
    end

    // Stream-level reference: what a correct loader writes and how it ends.
    task automatic model(input bq_t s, output bit e_done, output bit e_err);
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = int'({s[1], s[0]});
        e_done = 1'b0;
        e_err  = 1'b0;
        if (n > MAX_N) begin
            e_err = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(32'(i * 4));
                exp_data.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
            end
            x = 8'h00;
            for (int i = 0; i < s.size() - 1; i++) x = x ^ s[i];
            if (x == s[s.size()-1]) e_done = 1'b1;
            else                    e_err  = 1'b1;
        end
    endtask

    task automatic build_stream(input int n, input bit bad_chk, output bq_t s);
        logic [7:0] x;
        s.delete();
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (n <= MAX_N) begin
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
            x = 8'h00;
            foreach (s[i]) x = x ^ s[i];
            if (bad_chk) x = x ^ 8'(1 << $urandom_range(0, 7));
            s.push_back(x);
        end
    endtask

    // gap < 0 picks a random 0..2 idle cycles before each byte.
    task automatic run_stream(input bq_t s, input int gap);
        int g;
        bit ok;
        @(negedge clk_i);
        base = edge_cnt;
        foreach (s[i]) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            if (i > 0) begin
                bus.rx_valid_i = 1'b0;
                repeat (g) @(negedge clk_i);
            end
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = s[i];
            ok = 1'b0;
            for (int w = 0; w < 20 && !ok; w++) begin
                if (bus.rx_ready_o) ok = 1'b1;
                @(negedge clk_i);
            end
            if (!ok) begin
                check("rx_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        bus.rx_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic start_test(input bit offer_byte);
        @(negedge clk_i);
        bus.reload_i   = 1'b1;
        bus.rx_valid_i = offer_byte;
        bus.rx_data_i  = 8'h55;
        @(negedge clk_i);
        bus.reload_i   = 1'b0;
        bus.rx_valid_i = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic verify(input string tag, input bq_t s);
        bit e_done, e_err;
        int nw;
        model(s, e_done, e_err);
        check({tag, "_nwrites"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        nw = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
            check($sformatf("%s_wr%0d_data", tag, i), 64'(obs_data[i]), 64'(exp_data[i]));
        end
        check({tag, "_done"},     64'(bus.done_o),     64'(e_done));
        check({tag, "_err"},      64'(bus.err_o),      64'(e_err));
        check({tag, "_core_rst"}, 64'(bus.core_rst_o), 64'(!e_done));
        check({tag, "_busy"},     64'(bus.busy_o),     64'd0);
        check({tag, "_ready"},    64'(bus.rx_ready_o), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    64'(bus.rx_ready_o),  64'd1);
        check({tag, "_busy"},     64'(bus.busy_o),      64'd1);
        check({tag, "_core_rst"}, 64'(bus.core_rst_o),  64'd1);
        check({tag, "_we"},       64'(bus.mem_we_o),    64'd0);
        check({tag, "_addr"},     64'(bus.mem_addr_o),  64'd0);
        check({tag, "_wdata"},    64'(bus.mem_wdata_o), 64'd0);
        check({tag, "_done"},     64'(bus.done_o),      64'd0);
        check({tag, "_err"},      64'(bus.err_o),       64'd0);
    endtask

    bq_t s, s1, part;

    initial begin
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.reload_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("rst_hold");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("rst_rel");

        // Two-word load with exact cycle positions.
        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
        start_test(1'b0);
        run_stream(s1, 0);
        verify("t1", s1);
        check("t1_w0_cyc", 64'(obs_cyc.size() > 0 ? obs_cyc[0] : -1), 64'd7);
        check("t1_w1_cyc", 64'(obs_cyc.size() > 1 ? obs_cyc[1] : -1), 64'd11);
        check("t1_done_cyc", 64'(done_cyc), 64'd12);

        @(negedge clk_i);
        bus.reload_i = 1'b1;
        @(negedge clk_i);
        bus.reload_i = 1'b0;
        check("reload_core_rst", 64'(bus.core_rst_o), 64'd1);
        check("reload_done",     64'(bus.done_o),     64'd0);
        check("reload_busy",     64'(bus.busy_o),     64'd1);

        // Same stream, wrong checksum.
        s = s1;
        s[10] = 8'h18;
        start_test(1'b0);
        run_stream(s, 0);
        verify("t2", s);

        // Empty program.
        s = '{8'h00, 8'h00, 8'h00};
        start_test(1'b0);
        run_stream(s, 0);
        verify("t3", s);
        check("t3_done_cyc", 64'(done_cyc), 64'd4);

        // Oversize length.
        s = '{8'h01, 8'h04};
        start_test(1'b0);
        run_stream(s, 0);
        verify("t4", s);
        check("t4_err_cyc", 64'(err_cyc), 64'd3);

        // Full-capacity program.
        build_stream(MAX_N, 1'b0, s);
        start_test(1'b0);
        run_stream(s, 0);
        verify("t5", s);
        check("t5_last_addr", 64'(obs_addr.size() > 0 ? obs_addr[obs_addr.size()-1] : 32'hFFFF_FFFF), 64'hFFC);

        // Gapped partial load interrupted by reload with a byte offered.
        part = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        start_test(1'b0);
        run_stream(part, 2);
        start_test(1'b1);
        check("t6_reload_err",  64'(bus.err_o),  64'd0);
        check("t6_reload_done", 64'(bus.done_o), 64'd0);
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h8D};
        run_stream(s, 2);
        verify("t6", s);

        // Asynchronous reset after the 6th byte, then a full replay.
        start_test(1'b0);
        part = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        run_stream(part, 0);
        #2 rst_i = 1'b1;
        #1 check_reset_outputs("t7_async");
        @(negedge clk_i);
        rst_i = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc = -1;
        err_cyc  = -1;
        run_stream(s1, 0);
        verify("t7", s1);

        // Randomized streams, random pacing.
        for (int it = 0; it < 40; it++) begin
            int n;
            bit bad;
            n   = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_N + 1, 65535) : $urandom_range(0, 8);
            bad = ($urandom_range(0, 3) == 0);
            build_stream(n, bad, s);
            start_test(1'b1);
            run_stream(s, -1);
            verify($sformatf("rnd%0d", it), s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
